// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity constants, tx state type and timing helpers for the UART blocks
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud_rate);
        return clk_hz / baud_rate;
    endfunction

    function automatic int timer_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - valid/ready word stream from the producer into the UART transmitter
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - restartable divide-by-CLKS_PER_BIT counter with a last-clock pulse
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_end
);
    localparam int            W    = timer_width(CLKS_PER_BIT);
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    // Wrapping on every period keeps each bit exactly CLKS_PER_BIT clocks with no drift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter with one-entry holding register for gapless frames
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  s,
    output logic            txd,
    output logic            busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be within 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] hold_data;
    logic [DATA_BITS-1:0] load_word;
    logic                 hold_full;
    logic                 par_bit;
    logic [3:0]           bit_idx;
    logic                 bit_end;
    logic                 accept;
    logic                 last_stop;
    logic                 do_load;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == ST_IDLE),
        .bit_end (bit_end)
    );

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == PAR_ODD) ? ~^w : ^w;
    endfunction

    assign accept    = s.tx_valid && s.tx_ready;
    assign last_stop = (state == ST_STOP) && bit_end && (bit_idx == LAST_STOP);
    // A held word outranks a same-edge accept; tx_ready is low whenever one is held.
    assign do_load   = ((state == ST_IDLE) && accept) || (last_stop && (hold_full || accept));
    assign load_word = hold_full ? hold_data : s.tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            s.tx_ready <= 1'b1;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_idx    <= '0;
        end else begin
            if (do_load) begin
                state   <= ST_START;
                txd     <= 1'b0;
                busy    <= 1'b1;
                shreg   <= load_word;
                par_bit <= parity_of(load_word);
                bit_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        txd  <= 1'b1;
                        busy <= 1'b0;
                    end
                    ST_START: if (bit_end) begin
                        state   <= ST_DATA;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                    ST_DATA: if (bit_end) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PAR;
                                txd   <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    ST_PAR: if (bit_end) begin
                        state   <= ST_STOP;
                        txd     <= 1'b1;
                        bit_idx <= '0;
                    end
                    ST_STOP: if (bit_end) begin
                        if (bit_idx != LAST_STOP) begin
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            bit_idx <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (last_stop && hold_full) begin
                hold_full  <= 1'b0;
                s.tx_ready <= 1'b1;
            end else if (accept && !do_load) begin
                hold_full  <= 1'b1;
                hold_data  <= s.tx_data;
                s.tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame in 8N1, 7E2 and 7O2 configurations
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int CPB = 4;

    typedef struct packed {
        logic [15:0] bits;
        logic [7:0]  nbits;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] v;
    logic [2:0] rdy;
    logic [2:0] tx;
    logic [2:0] bz;
    logic [8:0] d [3];

    uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
    uart_tx_frame_if #(.DATA_BITS(7)) if_b ();
    uart_tx_frame_if #(.DATA_BITS(7)) if_c ();

    assign if_a.tx_valid = v[0];
    assign if_b.tx_valid = v[1];
    assign if_c.tx_valid = v[2];
    assign if_a.tx_data  = d[0][7:0];
    assign if_b.tx_data  = d[1][6:0];
    assign if_c.tx_data  = d[2][6:0];
    assign rdy = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};

    uart_tx_frame #(.CLK_HZ(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(if_a), .txd(tx[0]), .busy(bz[0]));
    uart_tx_frame #(.CLK_HZ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(if_b), .txd(tx[1]), .busy(bz[1]));
    uart_tx_frame #(.CLK_HZ(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .s(if_c), .txd(tx[2]), .busy(bz[2]));

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t cur [3];
    logic [2:0] in_f = '0;
    int   pos  [3] = '{0, 0, 0};
    int   done [3] = '{0, 0, 0};

    task automatic chk(input string name, input int k, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s ch%0d at cycle %0d: got %0d want %0d", name, k, cyc, act, want);
        end
    endtask

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        case (k)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: a low txd outside a frame opens the next expected frame, then every clock is compared.
    task automatic mon_step(input int k);
        exp_t e;
        int   b;
        if (!in_f[k] && tx[k] == 1'b0) begin
            if (qsize(k) == 0) begin
                chk("unexpected_start", k, 1, 0);
            end else begin
                cur[k] = qpop(k);
                in_f[k] = 1'b1;
                pos[k]  = 0;
            end
        end
        if (in_f[k]) begin
            e = cur[k];
            b = pos[k] / CPB;
            chk("txd_level", k, int'(tx[k]), int'(e.bits[b]));
            chk("busy_in_frame", k, int'(bz[k]), 1);
            pos[k]++;
            if (pos[k] == int'(e.nbits) * CPB) begin
                in_f[k] = 1'b0;
                done[k]++;
            end
        end else begin
            chk("busy_idle", k, int'(bz[k]), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_f = '0;
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int k = 0; k < 3; k++) mon_step(k);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with tx_valid still high.
    task automatic put(input int k, input logic [8:0] w, input logic [15:0] fr, input int nb);
        exp_t e;
        int   n;
        n = 0;
        e.bits  = fr;
        e.nbits = nb[7:0];
        qpush(k, e);
        d[k] = w;
        v[k] = 1'b1;
        while (!rdy[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", k, int'(rdy[k]), 1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int k, input int t0, output int len, output logic rlow);
        int n;
        n = 0;
        rlow = 1'b0;
        while (bz[k] && n < 3000) begin
            if (!rdy[k]) rlow = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("idle_reached", k, int'(bz[k]), 0);
        len = cyc - t0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100us want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0;
        int   t1;
        int   t2;
        int   len;
        logic rlow;

        rst_n = 1'b0;
        v     = '0;
        for (int k = 0; k < 3; k++) d[k] = '0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_txd", k, int'(tx[k]), 1);
            chk("reset_ready", k, int'(rdy[k]), 1);
            chk("reset_busy", k, int'(bz[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 single frame 0xA5
        put(0, 9'h0A5, 16'h034A, 10);
        t0 = cyc;
        v[0] = 1'b0;
        wait_idle(0, t0, len, rlow);
        chk("busy_len_a5", 0, len, 40);
        chk("ready_held_a5", 0, int'(rlow), 0);

        // Three words with tx_valid held high
        put(0, 9'h001, 16'h0202, 10);
        t0 = cyc;
        chk("ready_after_first", 0, int'(rdy[0]), 1);
        put(0, 9'h002, 16'h0204, 10);
        chk("ready_fall_second", 0, int'(rdy[0]), 0);
        put(0, 9'h003, 16'h0206, 10);
        chk("ready_fall_third", 0, int'(rdy[0]), 0);
        v[0] = 1'b0;
        wait_idle(0, t0, len, rlow);
        chk("busy_len_b2b", 0, len, 120);
        chk("ready_after_b2b", 0, int'(rdy[0]), 1);

        // Accept on the final stop clock with the holding register empty
        put(0, 9'h05A, 16'h02B4, 10);
        t0 = cyc;
        v[0] = 1'b0;
        while (cyc < t0 + 39) @(negedge clk);
        put(0, 9'h0C3, 16'h0386, 10);
        v[0] = 1'b0;
        chk("bypass_edge", 0, cyc - t0, 40);
        chk("bypass_start_txd", 0, int'(tx[0]), 0);
        chk("bypass_ready", 0, int'(rdy[0]), 1);
        wait_idle(0, t0, len, rlow);
        chk("busy_len_bypass", 0, len, 80);
        chk("ready_held_bypass", 0, int'(rlow), 0);

        // Reset mid-DATA with the holding register full
        put(0, 9'h000, 16'h0200, 10);
        t0 = cyc;
        put(0, 9'h011, 16'h0222, 10);
        v[0] = 1'b0;
        chk("hold_full_ready", 0, int'(rdy[0]), 0);
        while (cyc < t0 + 14) @(negedge clk);
        chk("mid_data_txd", 0, int'(tx[0]), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_txd", 0, int'(tx[0]), 1);
        chk("async_reset_ready", 0, int'(rdy[0]), 1);
        chk("async_reset_busy", 0, int'(bz[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        put(0, 9'h03C, 16'h0278, 10);
        t0 = cyc;
        v[0] = 1'b0;
        wait_idle(0, t0, len, rlow);
        chk("busy_len_after_reset", 0, len, 40);

        // 7E2 and 7O2: 0x53 then 0x7F queued behind it
        put(1, 9'h053, 16'h06A6, 11);
        t1 = cyc;
        v[1] = 1'b0;
        put(2, 9'h053, 16'h07A6, 11);
        t2 = cyc;
        v[2] = 1'b0;
        put(1, 9'h07F, 16'h07FE, 11);
        v[1] = 1'b0;
        chk("hold_b_ready", 1, int'(rdy[1]), 0);
        put(2, 9'h07F, 16'h06FE, 11);
        v[2] = 1'b0;
        wait_idle(1, t1, len, rlow);
        chk("busy_len_7e2", 1, len, 88);
        wait_idle(2, t2, len, rlow);
        chk("busy_len_7o2", 2, len, 88);

        @(negedge clk);
        chk("frames_done", 0, done[0], 7);
        chk("frames_done", 1, done[1], 2);
        chk("frames_done", 2, done[2], 2);
        for (int k = 0; k < 3; k++) chk("queue_empty", k, qsize(k), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
